// File: rtl/pio_ctrl_ext_if.sv
// Avalon-MM slave bus bundle for pio_ctrl_ext: word address, read/write strobes, data.
// Reads have fixed latency 1 and there is no waitrequest; a strobe is accepted on every clock it is high.
interface pio_ctrl_ext_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/pio_ctrl_ext.sv
// Parametrised PIO: per-bit direction, set/clear writes, synchronised inputs with sticky
// edge capture and maskable irq, and per-bit hardware blink from a programmable prescaler.
module pio_ctrl_ext #(
    parameter int               WIDTH      = 10,
    parameter logic [WIDTH-1:0] RESET_OUT  = '0,
    parameter logic [WIDTH-1:0] RESET_DIR  = '1,
    parameter int               EDGE_TYPE  = 0,
    parameter int               PRESCALE_W = 24
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    pio_ctrl_ext_if.slave    avs,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;
    localparam logic [2:0] A_BEN    = 3'd6;
    localparam logic [2:0] A_BPER   = 3'd7;

    logic [WIDTH-1:0]      out_reg, dir_reg, mask_reg, edge_reg, ben_reg;
    logic [WIDTH-1:0]      sync1, sync2, prev;
    logic [WIDTH-1:0]      edge_det, wdata;
    logic [PRESCALE_W-1:0] blink_per, prescaler, wper;
    logic                  blink_phase;
    logic [31:0]           rd_mux, readdata_q;
    logic                  wr_data, wr_dir, wr_mask, wr_edge, wr_set, wr_clr, wr_ben, wr_per;
    logic                  unused_wdata;

    assign wdata        = avs.avs_writedata[WIDTH-1:0];
    assign wper         = avs.avs_writedata[PRESCALE_W-1:0];
    assign unused_wdata = &{1'b0, avs.avs_writedata};

    assign wr_data = avs.avs_write && (avs.avs_address == A_DATA);
    assign wr_dir  = avs.avs_write && (avs.avs_address == A_DIR);
    assign wr_mask = avs.avs_write && (avs.avs_address == A_MASK);
    assign wr_edge = avs.avs_write && (avs.avs_address == A_EDGE);
    assign wr_set  = avs.avs_write && (avs.avs_address == A_OUTSET);
    assign wr_clr  = avs.avs_write && (avs.avs_address == A_OUTCLR);
    assign wr_ben  = avs.avs_write && (avs.avs_address == A_BEN);
    assign wr_per  = avs.avs_write && (avs.avs_address == A_BPER);

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0)      edge_det = sync2 & ~prev;
        else if (EDGE_TYPE == 1) edge_det = ~sync2 & prev;
        else                     edge_det = sync2 ^ prev;
    end

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            A_DATA:  rd_mux = 32'((dir_reg & out_reg) | (~dir_reg & sync2));
            A_DIR:   rd_mux = 32'(dir_reg);
            A_MASK:  rd_mux = 32'(mask_reg);
            A_EDGE:  rd_mux = 32'(edge_reg);
            A_BEN:   rd_mux = 32'(ben_reg);
            A_BPER:  rd_mux = 32'(blink_per);
            default: rd_mux = '0;
        endcase
    end

    // Input synchroniser plus prev stage: a pin change reaches edge_reg on the third clock.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pio_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_reg  <= RESET_OUT;
            dir_reg  <= RESET_DIR;
            mask_reg <= '0;
            edge_reg <= '0;
            ben_reg  <= '0;
        end else begin
            if (wr_data)     out_reg <= wdata;
            else if (wr_set) out_reg <= out_reg | wdata;
            else if (wr_clr) out_reg <= out_reg & ~wdata;
            if (wr_dir)  dir_reg  <= wdata;
            if (wr_mask) mask_reg <= wdata;
            if (wr_ben)  ben_reg  <= wdata;
            // A fresh edge in the same cycle as its W1C keeps the bit set.
            edge_reg <= (edge_reg & ~(wr_edge ? wdata : '0)) | edge_det;
        end
    end

    // Blink prescaler: phase holds for blink_per+1 clocks; period 0 means steady on.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            blink_per   <= '0;
            prescaler   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_per) begin
            blink_per   <= wper;
            prescaler   <= wper;
            blink_phase <= 1'b1;
        end else if (blink_per == '0) begin
            prescaler   <= '0;
            blink_phase <= 1'b1;
        end else if (prescaler == '0) begin
            prescaler   <= blink_per;
            blink_phase <= ~blink_phase;
        end else begin
            prescaler <= prescaler - 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)     readdata_q <= '0;
        else if (avs.avs_read)  readdata_q <= rd_mux;
    end

    assign avs.avs_readdata = readdata_q;
    assign irq     = |(edge_reg & mask_reg);
    assign pio_oe  = dir_reg;
    assign pio_out = out_reg & (~ben_reg | {WIDTH{blink_phase}});

endmodule

// File: tb/tb_pio_ctrl_ext.sv
// Bench for pio_ctrl_ext: directed scenarios plus randomized register/pin traffic, reads
// scored against a register-level reference model through an expected-value queue.
module tb_pio_ctrl_ext;
    localparam int         WIDTH     = 10;
    localparam int         EDGE_TYPE = 0;
    localparam logic [9:0] RESET_OUT = 10'h000;
    localparam logic [9:0] RESET_DIR = 10'h3FF;

    logic       clk;
    logic       rst_n;
    logic       irq;
    logic [9:0] pio_in, pio_out, pio_oe;

    pio_ctrl_ext_if bus ();

    pio_ctrl_ext #(
        .WIDTH(WIDTH), .RESET_OUT(RESET_OUT), .RESET_DIR(RESET_DIR),
        .EDGE_TYPE(EDGE_TYPE), .PRESCALE_W(24)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs(bus),
        .irq(irq), .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic        sb_on;
    logic        rd_fire = 1'b0;

    // reference model state
    logic [9:0]  m_out, m_dir, m_mask, m_edge, m_ben, m_in;
    logic [23:0] m_per;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] edges_of(input logic [9:0] old_v, input logic [9:0] new_v);
        if (EDGE_TYPE == 0)      return new_v & ~old_v;
        else if (EDGE_TYPE == 1) return ~new_v & old_v;
        else                     return new_v ^ old_v;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {22'd0, (m_dir & m_out) | (~m_dir & m_in)};
            3'd1:    return {22'd0, m_dir};
            3'd2:    return {22'd0, m_mask};
            3'd3:    return {22'd0, m_edge};
            3'd6:    return {22'd0, m_ben};
            3'd7:    return {8'd0, m_per};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = RESET_OUT; m_dir = RESET_DIR; m_mask = '0; m_edge = '0;
        m_ben = '0; m_per = '0; m_in = '0;
    endtask

    // driver tasks
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
        @(negedge clk);
        bus.avs_write = 1'b0;
        case (a)
            3'd0: m_out  = d[9:0];
            3'd1: m_dir  = d[9:0];
            3'd2: m_mask = d[9:0];
            3'd3: m_edge = m_edge & ~d[9:0];
            3'd4: m_out  = m_out | d[9:0];
            3'd5: m_out  = m_out & ~d[9:0];
            3'd6: m_ben  = d[9:0];
            default: m_per = d[23:0];
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        exp_q.push_back(model_read(a));
        bus.avs_read = 1'b1; bus.avs_address = a;
        @(negedge clk);
        bus.avs_read = 1'b0;
    endtask

    task automatic set_pins(input logic [9:0] v);
        @(negedge clk);
        pio_in = v;
        m_edge = m_edge | edges_of(m_in, v);
        m_in   = v;
        repeat (4) @(negedge clk);
    endtask

    // With blink period 0 the phase is steady on, so pins follow out_reg directly.
    task automatic check_pins();
        check("pio_out", {22'd0, pio_out}, {22'd0, m_out});
        check("pio_oe", {22'd0, pio_oe}, {22'd0, m_dir});
        check("irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
    endtask

    // scoreboard monitor: one read strobe -> readdata checked at the following negedge
    always @(posedge clk) rd_fire <= bus.avs_read & sb_on;
    always @(negedge clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) check("unexpected_read", bus.avs_readdata, 32'hDEAD_BEEF);
            else check("readdata", bus.avs_readdata, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sb_on = 1'b1; pio_in = '0;
        bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_address = '0; bus.avs_writedata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_readdata", bus.avs_readdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_pins();
        bus_read(3'd1);

        // set/clear composition
        bus_write(3'd0, 32'h0F0);
        bus_write(3'd4, 32'h003);
        bus_write(3'd5, 32'h010);
        check("outsetclr", {22'd0, pio_out}, 32'h0E3);
        bus_read(3'd0);

        // rising edge on bit0, exact 3-clock latency to capture
        bus_write(3'd1, 32'h000);
        bus_write(3'd2, 32'h001);
        bus_write(3'd3, 32'h3FF);
        @(negedge clk);
        pio_in = 10'h001;
        @(negedge clk); check("irq_lat1", {31'd0, irq}, 32'd0);
        @(negedge clk); check("irq_lat2", {31'd0, irq}, 32'd0);
        @(negedge clk); check("irq_lat3", {31'd0, irq}, 32'd1);
        m_edge = m_edge | edges_of(m_in, 10'h001);
        m_in   = 10'h001;
        bus_read(3'd3);
        bus_write(3'd2, 32'h000);
        check_pins();
        bus_read(3'd3);
        bus_write(3'd2, 32'h001);
        check_pins();
        bus_write(3'd3, 32'h001);
        check_pins();

        // W1C collides with a newly detected edge: edge wins
        set_pins(10'h000);
        @(negedge clk);
        pio_in = 10'h001;
        @(negedge clk);
        @(negedge clk);
        bus.avs_write = 1'b1; bus.avs_address = 3'd3; bus.avs_writedata = 32'h001;
        @(negedge clk);
        bus.avs_write = 1'b0;
        m_edge = m_edge | edges_of(m_in, 10'h001);
        m_in   = 10'h001;
        check("w1c_vs_edge_irq", {31'd0, irq}, 32'd1);
        bus_read(3'd3);
        bus_write(3'd3, 32'h3FF);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    logic [2:0] wa;
                    wa = 3'($urandom_range(0, 5));
                    if (wa == 3'd3) wa = 3'd6;
                    bus_write(wa, $urandom);
                end
                1: bus_write(3'd3, $urandom);
                2: set_pins(10'($urandom));
                default: bus_read(3'($urandom_range(0, 7)));
            endcase
            check_pins();
        end

        // blink on bit0, half-period 5
        bus_write(3'd2, 32'h000);
        bus_write(3'd1, 32'h3FF);
        bus_write(3'd0, 32'h001);
        bus_write(3'd6, 32'h001);
        bus_write(3'd7, 32'd4);
        for (int t = 0; t < 20; t++) begin
            check("blink", {22'd0, pio_out}, ((t / 5) % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        bus_read(3'd7);
        bus_write(3'd7, 32'd0);
        for (int t = 0; t < 6; t++) begin
            check("blink_steady", {22'd0, pio_out}, 32'd1);
            @(negedge clk);
        end
        bus_write(3'd6, 32'h000);

        // mixed direction read, then reset during a pending read
        bus_write(3'd3, 32'h3FF);
        set_pins(10'h000);
        bus_write(3'd1, 32'h00F);
        bus_write(3'd0, 32'h005);
        bus_write(3'd2, 32'h3FF);
        set_pins(10'h2AA);
        check_pins();
        bus_read(3'd0);
        sb_on = 1'b0;
        @(negedge clk);
        bus.avs_read = 1'b1; bus.avs_address = 3'd0;
        @(posedge clk);
        #2;
        check("pre_reset_rd", bus.avs_readdata, 32'h2A5);
        rst_n = 1'b0;
        #1;
        check("reset_rd", bus.avs_readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_out", {22'd0, pio_out}, {22'd0, RESET_OUT});
        check("reset_oe", {22'd0, pio_oe}, {22'd0, RESET_DIR});
        @(negedge clk);
        bus.avs_read = 1'b0; pio_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
